// File: rtl/dut_intf.sv
// Byte-stream packet mover: length words on len move that many bytes from din to dout.
// Includes a small FWFT FIFO and a register file for control, status and counters.

module dut_intf_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end
endmodule

// state | meaning
// IDLE  | waiting for a length word (L=0 completes immediately)
// XFER  | moving bytes din->dout until rem reaches 0
module dut_intf #(
  parameter int DIN_DEPTH  = 8,
  parameter int DOUT_DEPTH = 8,
  parameter int LEN_DEPTH  = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  din_value,
  input  logic        din_en,
  output logic        din_rdy,
  input  logic        dout_en,
  output logic [7:0]  dout_value,
  output logic        dout_rdy,
  input  logic [7:0]  len_value,
  input  logic        len_en,
  output logic        len_rdy,
  input  logic [7:0]  cfg_address,
  input  logic [31:0] cfg_data_in,
  input  logic        cfg_op,
  input  logic        cfg_en,
  output logic [31:0] cfg_data_out,
  output logic        cfg_rdy
);
  typedef enum logic {IDLE, XFER} state_t;

  localparam int DIN_CW  = $clog2(DIN_DEPTH + 1);
  localparam int DOUT_CW = $clog2(DOUT_DEPTH + 1);
  localparam int LEN_CW  = $clog2(LEN_DEPTH + 1);

  state_t              state;
  logic [7:0]          rem;
  logic [31:0]         byte_cnt, pkt_cnt, scratch, status, rdata;
  logic                enable;
  logic [7:0]          din_head, dout_head, len_head;
  logic [DIN_CW-1:0]   din_cnt;
  logic [DOUT_CW-1:0]  dout_cnt;
  logic [LEN_CW-1:0]   len_cnt;
  logic                din_full, din_empty, dout_full, dout_empty, len_full, len_empty;
  logic                move, len_pop;

  // RST_N is active-high; ready outputs are held low while it is asserted
  assign din_rdy    = !RST_N && !din_full;
  assign len_rdy    = !RST_N && !len_full;
  assign dout_rdy   = !dout_empty;
  assign dout_value = dout_rdy ? dout_head : 8'h00;
  assign cfg_rdy    = !RST_N;

  assign len_pop = (state == IDLE) && enable && !len_empty;
  assign move    = (state == XFER) && enable && !din_empty && !dout_full;

  dut_intf_fifo #(.DEPTH(DIN_DEPTH), .WIDTH(8)) u_din (
    .clk(CLK), .rst(RST_N), .wr_data(din_value), .push(din_en && din_rdy), .pop(move),
    .rd_data(din_head), .count(din_cnt), .full(din_full), .empty(din_empty)
  );

  dut_intf_fifo #(.DEPTH(DOUT_DEPTH), .WIDTH(8)) u_dout (
    .clk(CLK), .rst(RST_N), .wr_data(din_head), .push(move), .pop(dout_en && dout_rdy),
    .rd_data(dout_head), .count(dout_cnt), .full(dout_full), .empty(dout_empty)
  );

  dut_intf_fifo #(.DEPTH(LEN_DEPTH), .WIDTH(8)) u_len (
    .clk(CLK), .rst(RST_N), .wr_data(len_value), .push(len_en && len_rdy), .pop(len_pop),
    .rd_data(len_head), .count(len_cnt), .full(len_full), .empty(len_empty)
  );

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      state    <= IDLE;
      rem      <= 8'd0;
      byte_cnt <= 32'd0;
      pkt_cnt  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (len_pop) begin
            if (len_head == 8'd0) begin
              pkt_cnt <= pkt_cnt + 32'd1;
            end else begin
              rem   <= len_head;
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (move) begin
            rem      <= rem - 8'd1;
            byte_cnt <= byte_cnt + 32'd1;
            if (rem == 8'd1) begin
              pkt_cnt <= pkt_cnt + 32'd1;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status        = 32'd0;
    status[3:0]   = 4'(din_cnt);
    status[7:4]   = 4'(dout_cnt);
    status[9:8]   = 2'(len_cnt);
    status[16]    = (state == XFER);
  end

  always_comb begin
    rdata = 32'd0;
    case (cfg_address)
      8'h00:   rdata = {31'd0, enable};
      8'h04:   rdata = status;
      8'h08:   rdata = byte_cnt;
      8'h0C:   rdata = pkt_cnt;
      8'h10:   rdata = scratch;
      default: rdata = 32'd0;
    endcase
  end

  // Reads capture pre-increment counter values since rdata uses current registers
  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      enable       <= 1'b1;
      scratch      <= 32'd0;
      cfg_data_out <= 32'd0;
    end else if (cfg_en) begin
      if (cfg_op) begin
        if (cfg_address == 8'h00) enable  <= cfg_data_in[0];
        if (cfg_address == 8'h10) scratch <= cfg_data_in;
      end else begin
        cfg_data_out <= rdata;
      end
    end
  end
endmodule

// File: tb/tb_dut_intf.sv
// Scoreboard bench for dut_intf: accepted din bytes are queued as expected dout data,
// and counters/status are compared against a packet-level model at quiescent points.
module tb_dut_intf;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [7:0]  din_value = '0, dout_value, len_value = '0;
  logic        din_en = 1'b0, din_rdy, dout_en = 1'b0, dout_rdy, len_en = 1'b0, len_rdy;
  logic [7:0]  cfg_address = '0;
  logic [31:0] cfg_data_in = '0, cfg_data_out;
  logic        cfg_op = 1'b0, cfg_en = 1'b0, cfg_rdy;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  exp_q[$];
  int          lens[$];
  int          din_total = 0;
  logic [7:0]  exp_byte;
  logic [31:0] rd;

  dut_intf #(.DIN_DEPTH(8), .DOUT_DEPTH(8), .LEN_DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .din_value(din_value), .din_en(din_en), .din_rdy(din_rdy),
    .dout_en(dout_en), .dout_value(dout_value), .dout_rdy(dout_rdy),
    .len_value(len_value), .len_en(len_en), .len_rdy(len_rdy),
    .cfg_address(cfg_address), .cfg_data_in(cfg_data_in), .cfg_op(cfg_op), .cfg_en(cfg_en),
    .cfg_data_out(cfg_data_out), .cfg_rdy(cfg_rdy)
  );

  always #5 CLK = ~CLK;

  // stimulus capture and output monitor, both sampled away from the rising edge
  always @(negedge CLK) begin
    if (!RST_N) begin
      if (din_en && din_rdy) begin
        exp_q.push_back(din_value);
        din_total++;
      end
      if (len_en && len_rdy) lens.push_back(int'(len_value));
      if (dout_en && dout_rdy) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL dout_unexpected got %02h want nothing", dout_value);
        end else begin
          exp_byte = exp_q.pop_front();
          if (dout_value !== exp_byte) begin
            miscompares++;
            $display("FAIL dout_data got %02h want %02h", dout_value, exp_byte);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_address = a; cfg_data_in = d; cfg_op = 1'b1; cfg_en = 1'b1;
    tick(1);
    cfg_en = 1'b0;
  endtask

  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    cfg_address = a; cfg_op = 1'b0; cfg_en = 1'b1;
    tick(1);
    d = cfg_data_out;
    cfg_en = 1'b0;
  endtask

  task automatic din_put(input logic [7:0] v);
    din_value = v; din_en = 1'b1;
    tick(1);
    din_en = 1'b0;
  endtask

  task automatic len_put(input logic [7:0] v);
    len_value = v; len_en = 1'b1;
    tick(1);
    len_en = 1'b0;
  endtask

  task automatic do_reset();
    tick(1);
    RST_N = 1'b1;
    din_en = 1'b0; len_en = 1'b0; cfg_en = 1'b0; dout_en = 1'b1;
    exp_q.delete();
    lens.delete();
    din_total = 0;
    tick(2);
    check("rst_din_rdy", 32'(din_rdy), 32'd0);
    check("rst_len_rdy", 32'(len_rdy), 32'd0);
    check("rst_dout_rdy", 32'(dout_rdy), 32'd0);
    check("rst_dout_value", 32'(dout_value), 32'd0);
    check("rst_cfg_out", cfg_data_out, 32'd0);
    check("rst_cfg_rdy", 32'(cfg_rdy), 32'd0);
    RST_N = 1'b0;
    #1;
    check("run_din_rdy", 32'(din_rdy), 32'd1);
    check("run_len_rdy", 32'(len_rdy), 32'd1);
    check("run_cfg_rdy", 32'(cfg_rdy), 32'd1);
    tick(1);
  endtask

  // Packet-level model: packets complete in order while enough bytes have arrived;
  // the first packet that cannot complete is left in progress and absorbs what remains.
  task automatic check_model(input string tag);
    int acc, moved, pkts, busy, left;
    logic [31:0] r;
    acc = 0; pkts = 0; busy = 0; moved = 0;
    foreach (lens[i]) begin
      if (busy == 0) begin
        if (acc + lens[i] <= din_total) begin
          acc += lens[i];
          pkts++;
        end else begin
          busy = 1;
        end
      end
    end
    moved = busy ? din_total : acc;
    left  = lens.size() - pkts - busy;
    cfg_read(8'h08, r);
    check({tag, "_byte_cnt"}, r, 32'(moved));
    cfg_read(8'h0C, r);
    check({tag, "_pkt_cnt"}, r, 32'(pkts));
    cfg_read(8'h04, r);
    check({tag, "_status"}, r, 32'(din_total - moved) | (32'(left) << 8) | (32'(busy) << 16));
    check({tag, "_left_in_din"}, 32'(exp_q.size()), 32'(din_total - moved));
    check({tag, "_dout_empty"}, 32'(dout_rdy), 32'd0);
  endtask

  initial begin
    logic [7:0] pkt2 [4];
    pkt2[0] = 8'hA1; pkt2[1] = 8'hB2; pkt2[2] = 8'hC3; pkt2[3] = 8'hD4;

    tick(2);
    do_reset();
    cfg_read(8'h00, rd); check("ctrl_reset", rd, 32'd1);
    cfg_read(8'h10, rd); check("scratch_reset", rd, 32'd0);

    len_put(8'd3);
    for (int i = 0; i < 4; i++) din_put(pkt2[i]);
    tick(20);
    check_model("pkt3");
    cfg_read(8'h04, rd); check("pkt3_din_count", rd & 32'hF, 32'd1);

    do_reset();
    dout_en = 1'b1;
    for (int i = 0; i < 8; i++) din_put(8'h10 + 8'(i));
    check("full_din_rdy", 32'(din_rdy), 32'd0);
    din_put(8'h99);
    cfg_read(8'h04, rd); check("full_status", rd, 32'd8);
    len_put(8'd8);
    tick(30);
    check_model("drain8");

    do_reset();
    cfg_write(8'h00, 32'd0);
    len_put(8'd2);
    din_put(8'h5A);
    din_put(8'h6B);
    tick(10);
    check("paused_dout_rdy", 32'(dout_rdy), 32'd0);
    cfg_read(8'h04, rd); check("paused_status", rd, 32'h0000_0102);
    cfg_write(8'h00, 32'd1);
    tick(10);
    check_model("resume");

    do_reset();
    len_put(8'd0);
    len_put(8'd0);
    tick(5);
    check_model("zero_len");

    cfg_write(8'h10, 32'hDEAD_BEEF);
    cfg_read(8'h10, rd); check("scratch_rw", rd, 32'hDEAD_BEEF);
    cfg_write(8'h08, 32'h1234_5678);
    cfg_read(8'h08, rd); check("byte_cnt_ro", rd, 32'd0);
    cfg_write(8'h04, 32'hFFFF_FFFF);
    cfg_read(8'h04, rd); check("status_ro", rd, 32'd0);
    cfg_read(8'h40, rd); check("unmapped_rd", rd, 32'd0);
    cfg_write(8'h00, 32'hFFFF_FFFE);
    cfg_read(8'h00, rd); check("ctrl_off", rd, 32'd0);
    cfg_write(8'h00, 32'hFFFF_FFFF);
    cfg_read(8'h00, rd); check("ctrl_mask", rd, 32'd1);

    do_reset();
    for (int round = 0; round < 6; round++) begin
      for (int cyc = 0; cyc < 150; cyc++) begin
        din_en    = 1'($urandom_range(0, 1));
        din_value = 8'($urandom);
        len_en    = ($urandom_range(0, 7) == 0);
        len_value = 8'($urandom_range(0, 12));
        dout_en   = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          cfg_address = 8'h00; cfg_data_in = {31'd0, 1'($urandom)};
          cfg_op = 1'b1; cfg_en = 1'b1;
        end else begin
          cfg_en = 1'b0;
        end
        tick(1);
      end
      din_en = 1'b0; len_en = 1'b0; cfg_en = 1'b0;
      cfg_write(8'h00, 32'd1);
      dout_en = 1'b1;
      tick(40);
      check_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dut_intf.md
Name:
dut_intf

Overview:
- Byte-stream packet mover with three FIFO-style interfaces and one register interface.
- Length words queued on `len` select how many bytes the transfer engine moves from the `din` input FIFO to the `dout` output FIFO.
- The `cfg` port is a 32-bit register interface for control, status and counters.
- Sits between a byte producer and a byte consumer.
- Ports use ready/enable handshakes: `*_en` acts only while the matching `*_rdy` is high.

Parameters:
- DIN_DEPTH, 8, depth of the din FIFO in bytes.
- DOUT_DEPTH, 8, depth of the dout FIFO in bytes.
- LEN_DEPTH, 2, depth of the len FIFO in entries.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous, active-high (1 = reset), despite the name.
- din_value  input  8  byte to enqueue.
- din_en  input  1  enqueue din_value; ignored when din_rdy=0.
- din_rdy  output  1  din FIFO not full.
- dout_en  input  1  dequeue the head of the dout FIFO; ignored when dout_rdy=0.
- dout_value  output  8  head of the dout FIFO; valid while dout_rdy=1, otherwise 0.
- dout_rdy  output  1  dout FIFO not empty.
- len_value  input  8  packet length in bytes (0..255).
- len_en  input  1  enqueue len_value; ignored when len_rdy=0.
- len_rdy  output  1  len FIFO not full.
- cfg_address  input  8  register byte address.
- cfg_data_in  input  32  write data.
- cfg_op  input  1  0 = read, 1 = write.
- cfg_en  input  1  perform the cfg access.
- cfg_data_out  output  32  read data, registered.
- cfg_rdy  output  1  0 while in reset, 1 otherwise.

Behaviour:
- Reset (async assert):
  - All FIFOs empty, engine IDLE, counters 0, SCRATCH 0, CTRL.enable=1.
  - Outputs: din_rdy=0, len_rdy=0, dout_rdy=0, dout_value=0, cfg_data_out=0, cfg_rdy=0.
  - Ready outputs rise combinationally after reset deasserts.
  - Reset mid-packet discards all data and all counts.
- FIFOs:
  - Synchronous, first-word-fall-through.
  - Enqueue and dequeue in the same cycle are allowed; count is then unchanged.
  - A full FIFO never accepts data; an empty FIFO never pops.
- Engine, IDLE state:
  - If CTRL.enable=1 and the len FIFO is non-empty: pop L.
  - L=0: PKT_CNT+1, stay IDLE.
  - Else: REM<=L, go to XFER.
  - At most one len pop per cycle.
- Engine, XFER state:
  - Each cycle with din non-empty, dout not full and CTRL.enable=1: move one byte din→dout unchanged, REM-1, BYTE_CNT+1.
  - When REM goes 1→0: PKT_CNT+1, go to IDLE.
  - Throughput is 1 byte/cycle.
  - enable=0 pauses the transfer with no loss; it resumes at the same REM.
- Latency:
  - A byte enqueued at edge n (with the packet active) is moved at edge n+1.
  - dout_rdy is high after edge n+1.
  - Minimum din→dout latency is 2 cycles.
  - Same-cycle len enqueue: pop no earlier than the next edge.
- cfg interface:
  - Accesses are single-cycle when cfg_en=1.
  - Write: the register updates at that edge.
  - Read: cfg_data_out loads the value at that edge and holds it until the next read.
  - Unmapped address: reads return 0, writes are ignored.
  - Writes to read-only registers are ignored.
- Register map:
  - 0x00 CTRL (RW): bit0 enable; other bits read 0.
  - 0x04 STATUS (RO): [3:0] din count, [7:4] dout count, [9:8] len count, bit16 busy (engine in XFER), other bits 0.
  - 0x08 BYTE_CNT (RO): 32-bit count of bytes moved; wraps 0xFFFFFFFF→0.
  - 0x0C PKT_CNT (RO): 32-bit count of completed packets (including L=0); wraps.
  - 0x10 SCRATCH (RW): 32 bits.
- Simultaneous events:
  - A counter read returns the value from before that edge's increment.
  - A CTRL write takes effect for the engine from the next cycle.

Test Plan:
- Reset with stimulus idle → din_rdy=1, len_rdy=1, dout_rdy=0, cfg_rdy=1; read 0x00 → 1; read 0x10 → 0.
- len=3, then din 0xA1,0xB2,0xC3,0xD4 → dout yields A1,B2,C3 in order; D4 stays in the din FIFO; STATUS[3:0]=1; BYTE_CNT=3; PKT_CNT=1.
- Write 8 bytes with no len queued → din_rdy=0 after the 8th; a 9th din_en is ignored; len=8 then drains all 8 in order.
- Write CTRL=0, queue len=2 and 2 bytes → dout_rdy stays 0; write CTRL=1 → both bytes appear; PKT_CNT=1.
- len=0 twice → PKT_CNT=2, BYTE_CNT=0, no dout data.
- Write SCRATCH=0xDEADBEEF, read it back → 0xDEADBEEF; write 0x08 then read → BYTE_CNT unchanged; read 0x40 → 0.
